// File: rtl/proc_isa_pkg.sv
// ISA constants and sequencer state encoding shared by the fetch sequencer files.
package proc_isa_pkg;

  localparam int unsigned OpcW     = 6;
  localparam int unsigned OperandW = 10;

  // The sequencer decodes only these opcodes; every other code advances the PC.
  localparam logic [OpcW-1:0] OpcNop    = 6'd46;
  localparam logic [OpcW-1:0] OpcJumpnz = 6'd47;
  localparam logic [OpcW-1:0] OpcJumpz  = 6'd52;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StHalt,
    StStall
  } seq_state_e;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Host, instruction RAM and control-unit signals of the fetch sequencer.
// The step input exists only when SINGLE_STEP_EN is defined.
interface instr_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPC_W  = 6
);
  localparam int unsigned OperandW = DATA_W - OPC_W;

  logic                start;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_data;
  logic [OPC_W-1:0]    opcode;
  logic [OperandW-1:0] operand;
  logic                instr_valid;
  logic                instr_ack;
  logic                z_flag;
  logic [ADDR_W-1:0]   pc;
  logic                busy;
  logic                done;
  logic                err;
`ifdef SINGLE_STEP_EN
  logic                step;

  modport master (
    input  start, ram_data, instr_ack, z_flag, step,
    output ram_addr, opcode, operand, instr_valid, pc, busy, done, err
  );

  modport slave (
    output start, ram_data, instr_ack, z_flag, step,
    input  ram_addr, opcode, operand, instr_valid, pc, busy, done, err
  );
`else
  modport master (
    input  start, ram_data, instr_ack, z_flag,
    output ram_addr, opcode, operand, instr_valid, pc, busy, done, err
  );

  modport slave (
    output start, ram_data, instr_ack, z_flag,
    input  ram_addr, opcode, operand, instr_valid, pc, busy, done, err
  );
`endif

endinterface

// File: rtl/branch_resolve.sv
// Next-PC resolution for the issued instruction: NOP halts, taken JUMPZ/JUMPNZ load the
// operand, everything else falls through; flags a next PC outside the program.
module branch_resolve
  import proc_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned OPC_W     = OpcW,
  parameter int unsigned OPERAND_W = OperandW,
  parameter int unsigned PROG_LEN  = 165
) (
  input  logic [OPC_W-1:0]     opcode_i,
  input  logic [OPERAND_W-1:0] operand_i,
  input  logic                 z_flag_i,
  input  logic [ADDR_W-1:0]    pc_i,
  output logic [ADDR_W-1:0]    next_pc_o,
  output logic                 halt_o,
  output logic                 illegal_o
);

  // One extra bit so pc+1 and the range compare cannot wrap.
  localparam logic [ADDR_W:0] ProgLen = (ADDR_W + 1)'(PROG_LEN);

  logic            take_jump;
  logic [ADDR_W:0] pc_inc;
  logic [ADDR_W:0] target;

  // Decode the opcode and pick the successor address.
  always_comb begin
    halt_o    = (opcode_i == OpcNop);
    take_jump = ((opcode_i == OpcJumpz) && z_flag_i) ||
                ((opcode_i == OpcJumpnz) && !z_flag_i);
    pc_inc    = {1'b0, pc_i} + (ADDR_W + 1)'(1);
    target    = {1'b0, operand_i[ADDR_W-1:0]};
    next_pc_o = pc_i;
    illegal_o = 1'b0;
    if (halt_o) begin
      next_pc_o = pc_i;
    end else if (take_jump) begin
      next_pc_o = operand_i[ADDR_W-1:0];
      // The top operand bit addresses beyond the RAM, so it is always out of range.
      illegal_o = operand_i[OPERAND_W-1] || (target >= ProgLen);
    end else begin
      next_pc_o = pc_inc[ADDR_W-1:0];
      illegal_o = (pc_inc >= ProgLen);
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer: owns the PC, fetches from a 1-cycle-latency instruction RAM, issues each
// word over valid/ack and resolves conditional jumps. Halts on NOP or on an out-of-range PC.
// Build option SINGLE_STEP_EN: adds a step input and a STALL state before every fetch.
module instr_fetch_sequencer
  import proc_isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OPC_W      = OpcW,
  parameter int unsigned PROG_LEN   = 165,
  parameter int unsigned START_ADDR = 0
) (
  input logic                     clk,
  input logic                     rst,
  instr_fetch_sequencer_if.master bus
);

  localparam int unsigned OperandLen = DATA_W - OPC_W;
  localparam logic [ADDR_W-1:0] StartPc = ADDR_W'(START_ADDR);

  seq_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [OPC_W-1:0]        opcode_q, opcode_d;
  logic [OperandLen-1:0]   operand_q, operand_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [ADDR_W-1:0]       br_next_pc;
  logic                    br_halt;
  logic                    br_illegal;

  branch_resolve #(
    .ADDR_W    (ADDR_W),
    .OPC_W     (OPC_W),
    .OPERAND_W (OperandLen),
    .PROG_LEN  (PROG_LEN)
  ) u_branch_resolve (
    .opcode_i  (opcode_q),
    .operand_i (operand_q),
    .z_flag_i  (bus.z_flag),
    .pc_i      (pc_q),
    .next_pc_o (br_next_pc),
    .halt_o    (br_halt),
    .illegal_o (br_illegal)
  );

  // Next-state logic: sequencing, instruction capture and PC update on ack.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d = StFetch;
          pc_d    = StartPc;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        opcode_d  = bus.ram_data[DATA_W-1 -: OPC_W];
        operand_d = bus.ram_data[OperandLen-1:0];
        state_d   = StIssue;
      end
      StIssue: begin
        if (bus.instr_ack) begin
          if (br_halt) begin
            state_d = StHalt;
            done_d  = 1'b1;
          end else if (br_illegal) begin
            // PC stays on the offending instruction for post-mortem.
            state_d = StHalt;
            err_d   = 1'b1;
          end else begin
            pc_d = br_next_pc;
`ifdef SINGLE_STEP_EN
            state_d = bus.step ? StFetch : StStall;
`else
            state_d = StFetch;
`endif
          end
        end
      end
      StStall: begin
`ifdef SINGLE_STEP_EN
        if (bus.step) begin
          state_d = StFetch;
        end
`else
        state_d = StFetch;
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= StartPc;
      opcode_q  <= '0;
      operand_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.ram_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_valid = (state_q == StIssue);
  assign bus.busy        = (state_q == StFetch) || (state_q == StLatch) || (state_q == StIssue);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomized self-checking bench for instr_fetch_sequencer against a program-level
// interpreter model. Covers SINGLE_STEP_EN when the macro is defined.
module tb_instr_fetch_sequencer;

  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int OW   = 6;
  localparam int PL   = 165;
  localparam int NOP  = 46;
  localparam int JNZ  = 47;
  localparam int JZ   = 52;
  localparam int INAC = 7;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [512];
  bit          jz_q [$];

  always #5 clk = ~clk;

  instr_fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(OW)) bus ();

  instr_fetch_sequencer #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .OPC_W      (OW),
    .PROG_LEN   (PL),
    .START_ADDR (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous instruction RAM, one cycle read latency.
  always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] mk(input int op, input int opd);
    return {op[5:0], opd[9:0]};
  endfunction

  function automatic int rand_plain_op();
    int o;
    do o = $urandom_range(0, 63); while (o == NOP || o == JNZ || o == JZ);
    return o;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 512; i++) mem[i] = mk(rand_plain_op(), $urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instr_ack = 1'b0;
    bus.z_flag = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  // Start the program at 0 and interpret it alongside the DUT, acking every issue.
  task automatic run_program(input int max_issues, input int dmin, input int dmax,
                             output bit finished, output int issues);
    int exp_pc, lat, op, opd, nxt, dly;
    bit z, tk, fin, exp_done, exp_err;
    logic [OW-1:0] s_op;
    logic [9:0] s_opd;
    exp_pc = 0; fin = 0; exp_done = 0; exp_err = 0; issues = 0;
    pulse_start();
    lat = 1;
    while (!fin && issues < max_issues) begin
      while (!bus.instr_valid && lat < 20) begin cyc(1); lat++; end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL latency issue %0d: got %0d cycles, want 3", issues, lat);
        if (!bus.instr_valid) begin do_reset(); finished = 0; return; end
      end
      op = int'(mem[exp_pc][15:10]);
      opd = int'(mem[exp_pc][9:0]);
      checks++;
      if (bus.pc !== exp_pc[AW-1:0] || bus.ram_addr !== exp_pc[AW-1:0]) begin
        errors++;
        $display("FAIL pc issue %0d: got %0d, want %0d", issues, bus.pc, exp_pc);
      end
      checks++;
      if (bus.opcode !== op[OW-1:0] || bus.operand !== opd[9:0]) begin
        errors++;
        $display("FAIL instr issue %0d: got %0d/%0d, want %0d/%0d", issues, bus.opcode,
                 bus.operand, op, opd);
      end
      s_op = bus.opcode; s_opd = bus.operand;
      dly = $urandom_range(dmin, dmax);
      if (dly > 0) begin
        cyc(dly);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.opcode !== s_op || bus.operand !== s_opd) begin
          errors++;
          $display("FAIL hold issue %0d: valid %0b opc %0d, want 1 opc %0d", issues,
                   bus.instr_valid, bus.opcode, s_op);
        end
      end
      if ((op == JZ || op == JNZ) && jz_q.size() > 0) z = jz_q.pop_front();
      else z = 1'($urandom_range(0, 1));
      bus.instr_ack = 1'b1;
      bus.z_flag = z;
`ifdef SINGLE_STEP_EN
      bus.step = 1'b1;
`endif
      cyc(1);
      bus.instr_ack = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step = 1'b0;
`endif
      lat = 1;
      issues++;
      if (op == NOP) begin
        fin = 1; exp_done = 1;
      end else begin
        tk = (op == JZ && z) || (op == JNZ && !z);
        nxt = tk ? opd : exp_pc + 1;
        if (nxt >= PL) begin fin = 1; exp_err = 1; end
        else exp_pc = nxt;
      end
    end
    finished = fin;
    if (fin) begin
      cyc(2);
      checks++;
      if (bus.done !== exp_done || bus.err !== exp_err) begin
        errors++;
        $display("FAIL halt flags: got done %0b err %0b, want done %0b err %0b", bus.done,
                 bus.err, exp_done, exp_err);
      end
      checks++;
      if (bus.pc !== exp_pc[AW-1:0] || bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt state: got pc %0d busy %0b valid %0b, want pc %0d busy 0 valid 0",
                 bus.pc, bus.busy, bus.instr_valid, exp_pc);
      end
    end else begin
      do_reset();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    do_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got busy %0b valid %0b done %0b err %0b, want all 0",
               bus.busy, bus.instr_valid, bus.done, bus.err);
    end
    checks++;
    if (bus.pc !== '0 || bus.opcode !== '0 || bus.operand !== '0) begin
      errors++;
      $display("FAIL reset regs: got pc %0d opc %0d opd %0d, want 0", bus.pc, bus.opcode,
               bus.operand);
    end
  endtask

  task automatic test_linear();
    bit fin; int n;
    fill_plain();
    for (int i = 0; i < 5; i++) mem[i] = mk(INAC, i);
    mem[5] = mk(NOP, 0);
    run_program(20, 1, 1, fin, n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL linear count: got %0d, want 6", n); end
  endtask

  task automatic test_jumpnz();
    bit fin; int n;
    fill_plain();
    mem[163] = mk(JNZ, 63);
    mem[164] = mk(NOP, 0);
    jz_q = '{1'b0, 1'b1};
    run_program(400, 0, 2, fin, n);
    checks++;
    if (n != 266) begin errors++; $display("FAIL jumpnz count: got %0d, want 266", n); end
  endtask

  task automatic test_jumpz();
    bit fin; int n;
    fill_plain();
    mem[143] = mk(JZ, 159);
    mem[164] = mk(NOP, 0);
    jz_q = '{1'b1};
    run_program(400, 0, 1, fin, n);
    checks++;
    if (n != 150) begin errors++; $display("FAIL jumpz taken count: got %0d, want 150", n); end
    jz_q = '{1'b0};
    run_program(400, 0, 1, fin, n);
    checks++;
    if (n != 165) begin errors++; $display("FAIL jumpz fall count: got %0d, want 165", n); end
  endtask

  task automatic test_err_end();
    bit fin; int n;
    fill_plain();
    jz_q.delete();
    run_program(400, 0, 0, fin, n);
    checks++;
    if (!fin || bus.err !== 1'b1 || bus.pc !== 9'd164) begin
      errors++;
      $display("FAIL end err: got err %0b pc %0d, want err 1 pc 164", bus.err, bus.pc);
    end
    pulse_start();
    checks++;
    if (bus.err !== 1'b0 || bus.done !== 1'b0 || bus.pc !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart: got err %0b done %0b pc %0d busy %0b, want 0 0 0 1", bus.err,
               bus.done, bus.pc, bus.busy);
    end
    do_reset();
  endtask

  task automatic test_jump_oob();
    bit fin; int n;
    fill_plain();
    mem[5] = mk(JZ, 200);
    jz_q = '{1'b1};
    run_program(20, 0, 1, fin, n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL oob count: got %0d, want 6", n); end
    mem[5] = mk(JNZ, 512 + 3);
    jz_q = '{1'b0};
    run_program(20, 0, 1, fin, n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL bit9 count: got %0d, want 6", n); end
  endtask

  task automatic test_rst_in_issue();
    fill_plain();
    mem[2] = mk(INAC, 341);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      cyc(2);
      if (k < 2) begin
        bus.instr_ack = 1'b1; cyc(1); bus.instr_ack = 1'b0;
      end
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc !== 9'd2 || bus.operand !== 10'd341) begin
      errors++;
      $display("FAIL pre-rst issue: got valid %0b pc %0d opd %0d, want 1 2 341",
               bus.instr_valid, bus.pc, bus.operand);
    end
    rst = 1'b1;
    cyc(1);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== '0 ||
        bus.opcode !== '0 || bus.operand !== '0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst in issue: got valid %0b busy %0b pc %0d opc %0d, want 0 0 0 0",
               bus.instr_valid, bus.busy, bus.pc, bus.opcode);
    end
    rst = 1'b0;
  endtask

  task automatic test_start_busy_hold();
    logic [OW-1:0] s_op;
    logic [9:0] s_opd;
    fill_plain();
    pulse_start();
    pulse_start();
    cyc(1);
    s_op = mem[0][15:10];
    s_opd = mem[0][9:0];
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.start = 1'b1;
      if (i == 5) bus.start = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.opcode !== s_op || bus.operand !== s_opd ||
          bus.pc !== '0) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid %0b opc %0d pc %0d, want 1 %0d 0", i,
                 bus.instr_valid, bus.opcode, bus.pc, s_op);
      end
      cyc(1);
    end
    bus.instr_ack = 1'b1;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    cyc(1);
    bus.instr_ack = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    cyc(2);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc !== 9'd1) begin
      errors++;
      $display("FAIL after ignored start: got valid %0b pc %0d, want 1 1", bus.instr_valid,
               bus.pc);
    end
    do_reset();
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_stall();
    fill_plain();
    pulse_start();
    cyc(2);
    bus.instr_ack = 1'b1; cyc(1); bus.instr_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== 9'd1) begin
        errors++;
        $display("FAIL stall cycle %0d: got valid %0b busy %0b pc %0d, want 0 0 1", i,
                 bus.instr_valid, bus.busy, bus.pc);
      end
      cyc(1);
    end
    bus.step = 1'b1; cyc(1); bus.step = 1'b0;
    cyc(2);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc !== 9'd1) begin
      errors++;
      $display("FAIL step resume: got valid %0b pc %0d, want 1 1", bus.instr_valid, bus.pc);
    end
    do_reset();
  endtask
`endif

  task automatic test_random();
    bit fin; int n, r;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 512; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8) mem[i] = mk((r < 4) ? JZ : JNZ, $urandom_range(0, 200));
        else if (r < 11) mem[i] = mk(NOP, $urandom_range(0, 1023));
        else mem[i] = mk(rand_plain_op(), $urandom_range(0, 1023));
      end
      jz_q.delete();
      run_program(150, 0, 3, fin, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instr_ack = 1'b0;
    bus.z_flag = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    test_reset();
    test_linear();
    test_jumpnz();
    test_jumpz();
    test_err_end();
    test_jump_oob();
    test_rst_in_issue();
    test_start_busy_hold();
`ifdef SINGLE_STEP_EN
    test_stall();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
